// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: word type plus ALU, compare and RV32M operation encodings.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } cmp_ops;

  // Encoded as the RV32M funct3 so decode can pass funct3 straight through.
  typedef enum logic [2:0] {
    mul    = 3'b000,
    mulh   = 3'b001,
    mulhsu = 3'b010,
    mulhu  = 3'b011,
    div    = 3'b100,
    divu   = 3'b101,
    rem    = 3'b110,
    remu   = 3'b111
  } muldiv_ops;

  function automatic logic is_div_op(input muldiv_ops o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies/divides in a single cycle.
module muldiv_unit
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      req_valid,
  output logic      req_ready,
  input  muldiv_ops op,
  input  rv32i_word a,
  input  rv32i_word b,
  output logic      resp_valid,
  input  logic      resp_ready,
  output rv32i_word f
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t    state;
  logic [5:0] cnt;
  logic [63:0] acc;
  rv32i_word quo;
  rv32i_word rem_r;
  rv32i_word opnd;
  muldiv_ops op_q;
  logic      neg_q;
  logic      rneg_q;

  logic      signed_div, sa, sb;
  rv32i_word mag_a, mag_b;
  logic      div_zero, ovf, early, fast;
  rv32i_word fast_f;

  // Operand sign/magnitude decode and single-cycle special cases for the request on the bus.
  always_comb begin
    signed_div = (op == div) || (op == rem);
    sa         = 1'b0;
    sb         = 1'b0;
    if (is_div_op(op)) begin
      sa = signed_div & a[31];
      sb = signed_div & b[31];
    end else begin
      sa = (op != mulhu) & a[31];
      sb = ((op == mul) || (op == mulh)) & b[31];
    end
    mag_a    = sa ? (~a + 32'd1) : a;
    mag_b    = sb ? (~b + 32'd1) : b;
    div_zero = is_div_op(op) && (b == 32'd0);
    ovf      = signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
    early    = is_div_op(op) ? ((a == 32'd0) && (b != 32'd0)) : ((a == 32'd0) || (b == 32'd0));
`else
    early    = 1'b0;
`endif
    fast     = div_zero || ovf || early;
    fast_f   = 32'd0;
    if (div_zero)
      fast_f = ((op == div) || (op == divu)) ? 32'hFFFF_FFFF : a;
    else if (ovf)
      fast_f = (op == div) ? 32'h8000_0000 : 32'd0;
  end

  logic [32:0] sum33;
  logic [63:0] acc_nxt;
  logic [32:0] shifted33, diff33;
  logic        ge;
  rv32i_word   quo_nxt, rem_nxt;
  logic [63:0] prod;
  rv32i_word   q_fin, r_fin, result;

  // One radix-2 step of each datapath, plus sign correction of the finished values.
  always_comb begin
    sum33     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    acc_nxt   = {sum33, acc[31:1]};
    shifted33 = {rem_r, quo[31]};
    diff33    = shifted33 - {1'b0, opnd};
    ge        = ~diff33[32];
    rem_nxt   = ge ? diff33[31:0] : shifted33[31:0];
    quo_nxt   = {quo[30:0], ge};
    prod      = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
    q_fin     = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    r_fin     = rneg_q ? (~rem_nxt + 32'd1) : rem_nxt;
    result    = 32'd0;
    case (op_q)
      mul:                result = prod[31:0];
      mulh, mulhsu, mulhu: result = prod[63:32];
      div, divu:          result = q_fin;
      rem, remu:          result = r_fin;
      default:            result = 32'd0;
    endcase
  end

  // Control FSM; flush wins over everything and discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      acc        <= 64'd0;
      quo        <= 32'd0;
      rem_r      <= 32'd0;
      opnd       <= 32'd0;
      op_q       <= mul;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
      f          <= 32'd0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= op;
            neg_q     <= sa ^ sb;
            rneg_q    <= sa;
            cnt       <= 6'd0;
            req_ready <= 1'b0;
            if (fast) begin
              f          <= fast_f;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= BUSY;
              if (is_div_op(op)) begin
                opnd  <= mag_b;
                quo   <= mag_a;
                rem_r <= 32'd0;
              end else begin
                opnd <= mag_a;
                acc  <= {32'd0, mag_b};
              end
            end
          end
        end
        BUSY: begin
          if (is_div_op(op_q)) begin
            quo   <= quo_nxt;
            rem_r <= rem_nxt;
          end else begin
            acc <= acc_nxt;
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            f          <= result;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: an arithmetic reference model predicts result and latency.
// Honours MULDIV_EARLY_OUT_EN the same way the design does.
module tb_muldiv_unit;
  import rv32i_types::*;

  logic      clk;
  logic      rst_n;
  logic      flush;
  logic      req_valid;
  logic      req_ready;
  muldiv_ops op;
  rv32i_word a;
  rv32i_word b;
  logic      resp_valid;
  logic      resp_ready;
  rv32i_word f;

  typedef struct {
    rv32i_word f;
    int        lat;
  } exp_t;

  exp_t sb_q[$];
  int   check_count = 0;
  int   error_count = 0;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .f          (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic rv32i_word refModel(input muldiv_ops o, input rv32i_word x, input rv32i_word y);
    longint      px, py;
    logic [63:0] p;
    int          sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    px = longint'(sx);
    py = longint'(sy);
    case (o)
      mul:    begin p = px * py; return p[31:0]; end
      mulh:   begin p = px * py; return p[63:32]; end
      mulhsu: begin p = px * longint'({32'd0, y}); return p[63:32]; end
      mulhu:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      div:    if (y == 0) return 32'hFFFF_FFFF;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
              else return rv32i_word'(sx / sy);
      divu:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      rem:    if (y == 0) return x;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
              else return rv32i_word'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int refLatency(input muldiv_ops o, input rv32i_word x, input rv32i_word y);
    logic d;
    d = o[2];
    if (d && y == 0) return 1;
    if ((o == div || o == rem) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (d ? (x == 0 && y != 0) : (x == 0 || y == 0)) return 1;
`endif
    return 33;
  endfunction

  // Drive one request, scramble the inputs after acceptance, then collect and check the response.
  task automatic applyStimulus(input muldiv_ops o, input rv32i_word x, input rv32i_word y, input int hold);
    exp_t e;
    int   lat;
    rv32i_word held;
    @(negedge clk);
    op = o; a = x; b = y; req_valid = 1'b1; resp_ready = 1'b0;
    checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = muldiv_ops'($urandom_range(0, 7));
    a = $urandom;
    b = $urandom;
    sb_q.push_back('{f: refModel(o, x, y), lat: refLatency(o, x, y)});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 100);
    e = sb_q.pop_front();
    checkOutput($sformatf("latency %s", o.name()), lat, e.lat);
    checkOutput($sformatf("f %s %h %h", o.name(), x, y), f, e.f);
    held = f;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_f", f, held);
      checkOutput("hold_valid", {30'd0, resp_valid, req_ready}, 32'd2);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("release", {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    op = mul; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {29'd0, resp_valid, req_ready, |f}, 32'd2);
    #1 rst_n = 1'b1;

    applyStimulus(mul,    32'd7,          32'hFFFF_FFFD, 0);
    applyStimulus(mulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    applyStimulus(mulh,   32'h8000_0000,  32'h8000_0000, 0);
    applyStimulus(mulhsu, 32'hFFFF_FFFF,  32'd2,         0);
    applyStimulus(div,    32'hFFFF_FFEC,  32'd3,         5);
    applyStimulus(rem,    32'hFFFF_FFEC,  32'd3,         0);
    applyStimulus(divu,   32'hFFFF_FFFF,  32'd2,         0);
    applyStimulus(remu,   32'd100,        32'd7,         0);
    applyStimulus(div,    32'd5,          32'd0,         0);
    applyStimulus(rem,    32'h8000_0000,  32'hFFFF_FFFF, 0);
    applyStimulus(div,    32'h8000_0000,  32'hFFFF_FFFF, 0);
    applyStimulus(remu,   32'd9,          32'd0,         0);
    applyStimulus(mul,    32'd0,          32'd9,         0);
    applyStimulus(div,    32'd0,          32'd5,         0);
    for (int i = 0; i < 8; i++)
      applyStimulus(muldiv_ops'($urandom_range(0, 7)), $urandom, $urandom, 0);

    // Flush in the tenth cycle after acceptance must kill the multiply silently.
    @(negedge clk);
    op = mul; a = 32'd11; b = 32'd13; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_idle", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("flush_no_resp", seen, 32'd0);
    applyStimulus(mul, 32'd11, 32'd13, 0);

    // A request presented together with flush is ignored.
    @(negedge clk);
    op = mul; a = 32'd3; b = 32'd4; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("flush_req_ignored", seen, 32'd0);

    // Reset mid-BUSY clears outputs immediately; f holds a nonzero value beforehand.
    applyStimulus(mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    op = divu; a = 32'd1000; b = 32'd7; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_busy", {29'd0, resp_valid, req_ready, |f}, 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(divu, 32'd1000, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
